// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding and sizing helpers
// for the parametrised sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  function automatic int fill_w(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/seq_sym_window.sv
// seq_sym_window: SEQ_LEN x SYM_W symbol shift register.
// Newest symbol enters at the top; bits [SYM_W-1:0] hold the oldest.
module seq_sym_window #(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift,
  input  logic [SYM_W-1:0]         sym,
  output logic [SEQ_LEN*SYM_W-1:0] win
);

  localparam int W = SEQ_LEN * SYM_W;

  // shift in one symbol per accepted cycle, hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win <= '0;
    end else if (shift) begin
      win <= {sym, win[W-1:SYM_W]};
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: programmable overlapping/non-overlapping detector.
// Macro SEQ_DET_COUNT_EN adds the saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     overlap,
  input  logic                     cfg_load,
  input  logic [SEQ_LEN*SYM_W-1:0] pattern,
  input  logic [SYM_W-1:0]         x,
  input  logic                     x_valid,
  output logic                     z,
  output logic [1:0]               state,
  output logic                     cfg_err,
  output logic [CNT_W-1:0]         match_count
);

  localparam int W  = SEQ_LEN * SYM_W;
  localparam int FW = fill_w(SEQ_LEN);
  localparam logic [FW-1:0] LAST = FW'(SEQ_LEN - 1);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);
  localparam logic [FW-1:0] ONE  = FW'(1);

  logic [SYM_W-1:0] x_q;
  logic             v_q;
  logic [W-1:0]     pat_q;
  logic [W-1:0]     win;
  logic [W-1:0]     nxt;
  logic [FW-1:0]    fill;
  state_e           st;
  logic             in_fill;
  logic             in_run;
  logic             fill_done;
  logic             hit;

  assign state = st;

  // register the incoming symbol and its qualifier
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      v_q <= 1'b0;
    end else begin
      x_q <= x;
      v_q <= x_valid;
    end
  end

  seq_sym_window #(
    .SYM_W  (SYM_W),
    .SEQ_LEN(SEQ_LEN)
  ) u_win (
    .clk  (clk),
    .reset(reset),
    .shift(v_q),
    .sym  (x_q),
    .win  (win)
  );

  assign nxt       = {x_q, win[W-1:SYM_W]};
  assign in_fill   = (st == ST_FILL);
  assign in_run    = (st == ST_RUN);
  assign fill_done = in_fill && (fill == LAST);
  assign hit       = enable && v_q
                   && (fill_done || in_run)
                   && (nxt == pat_q);

  // detector FSM, pattern register and config guard
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= ST_IDLE;
      fill    <= '0;
      z       <= 1'b0;
      cfg_err <= 1'b0;
      pat_q   <= '0;
    end else begin
      z       <= hit;
      cfg_err <= 1'b0;
      if (cfg_load) begin
        if (in_fill || in_run) cfg_err <= 1'b1;
        else                   pat_q   <= pattern;
      end
      if (!enable) begin
        st   <= ST_IDLE;
        fill <= '0;
      end else begin
        unique case (1'b1)
          in_fill: begin
            if (v_q) begin
              if (!fill_done) begin
                fill <= fill + ONE;
              end else if (hit && !overlap) begin
                fill <= '0;
              end else begin
                st   <= ST_RUN;
                fill <= FULL;
              end
            end
          end
          in_run: begin
            if (hit && !overlap) begin
              st   <= ST_FILL;
              fill <= '0;
            end
          end
          default: begin
            st   <= ST_FILL;
            fill <= '0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_DET_COUNT_EN
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // count matches, sticking at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (hit && (cnt != CMAX)) begin
      cnt <= cnt + C_ONE;
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench for seq_detector_param
// (SYM_W=2, SEQ_LEN=3, CNT_W=2).
module tb_seq_detector_param;

  localparam int SW = 2;
  localparam int SL = 3;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SEQ_DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [5:0] P321 = {2'd3, 2'd2, 2'd1};
  localparam logic [5:0] P111 = {2'd1, 2'd1, 2'd1};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          overlap = 1'b0;
  logic          cfg_load = 1'b0;
  logic [5:0]    pattern = '0;
  logic [SW-1:0] x = '0;
  logic          x_valid = 1'b0;
  logic          z;
  logic [1:0]    state;
  logic          cfg_err;
  logic [CW-1:0] match_count;

  always #5 clk = ~clk;

  seq_detector_param #(
    .SYM_W  (SW),
    .SEQ_LEN(SL),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .overlap    (overlap),
    .cfg_load   (cfg_load),
    .pattern    (pattern),
    .x          (x),
    .x_valid    (x_valid),
    .z          (z),
    .state      (state),
    .cfg_err    (cfg_err),
    .match_count(match_count)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  bit         expq[$];
  int         hist[$];
  int         fresh = 0;
  logic [5:0] mpat = '0;
  bit         mov = 1'b0;
  int         mcnt = 0;
  int         pulses = 0;
  bit         exp_err = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // sequence-level reference: last SL accepted symbols vs pattern
  task automatic model(input bit v, input int s, output bit e);
    e = 1'b0;
    if (v) begin
      hist.push_back(s);
      if (hist.size() > SL) void'(hist.pop_front());
      fresh++;
      if (fresh >= SL &&
          hist[0] == int'(mpat[1:0]) &&
          hist[1] == int'(mpat[3:2]) &&
          hist[2] == int'(mpat[5:4])) begin
        e = 1'b1;
        if (!mov) fresh = 0;
      end
    end
  endtask

  task automatic step(input bit v, input int s);
    bit e;
    bit ge;
    x_valid = v;
    x = SW'(s);
    model(v, s, e);
    expq.push_back(e);
    @(posedge clk);
    #1;
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    if (expq.size() > 1) begin
      ge = expq.pop_front();
      check("z", 32'(z), 32'(ge));
      if (z) pulses++;
      if (ge && CNT_ON && mcnt < CMAX) mcnt++;
      check("match_count", 32'(match_count), 32'(mcnt));
    end
  endtask

  task automatic drain();
    step(1'b0, 0);
    step(1'b0, 0);
  endtask

  task automatic run3(input int a, input int b, input int c);
    step(1'b1, a);
    step(1'b1, b);
    step(1'b1, c);
  endtask

  task automatic arm(input logic [5:0] p, input bit ov);
    hist.delete();
    fresh = 0;
    mpat = p;
    mov = ov;
    enable = 1'b0;
    step(1'b0, 0);
    cfg_load = 1'b1;
    pattern = p;
    enable = 1'b1;
    overlap = ov;
    step(1'b0, 0);
    cfg_load = 1'b0;
    step(1'b0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_z"}, 32'(z), 32'd0);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_count"}, 32'(match_count), 32'd0);
  endtask

  initial begin
    #2;
    check_zero("reset");
    #10;
    reset = 1'b1;

    arm(P321, 1'b1);
    pulses = 0;
    run3(1, 2, 3);
    drain();
    check("basic_pulses", 32'(pulses), 32'd1);
    check("basic_state", 32'(state), 32'd2);

    exp_err = 1'b1;
    cfg_load = 1'b1;
    pattern = '0;
    step(1'b0, 3);
    cfg_load = 1'b0;
    exp_err = 1'b0;
    pulses = 0;
    run3(1, 2, 3);
    drain();
    check("guard_pulses", 32'(pulses), 32'd1);

    arm(P321, 1'b1);
    pulses = 0;
    step(1'b1, 1);
    repeat (4) step(1'b0, 3);
    step(1'b1, 2);
    step(1'b1, 3);
    drain();
    check("gap_pulses", 32'(pulses), 32'd1);

    arm(P321, 1'b1);
    pulses = 0;
    step(1'b1, 1);
    run3(2, 2, 3);
    drain();
    check("nomatch_pulses", 32'(pulses), 32'd0);

    arm(P111, 1'b1);
    pulses = 0;
    repeat (5) step(1'b1, 1);
    drain();
    check("ovl1_pulses", 32'(pulses), 32'd3);

    arm(P111, 1'b0);
    pulses = 0;
    repeat (5) step(1'b1, 1);
    drain();
    check("ovl0_pulses", 32'(pulses), 32'd1);

    arm(P321, 1'b1);
    step(1'b1, 1);
    step(1'b1, 2);
    reset = 1'b0;
    x_valid = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    check_zero("midrst_hold");
    reset = 1'b1;
    expq.delete();
    hist.delete();
    fresh = 0;
    mcnt = 0;
    mpat = '0;
    pulses = 0;
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b1, 3);
    drain();
    check("postrst_pulses", 32'(pulses), 32'd0);

    arm(P321, 1'b1);
    pulses = 0;
    run3(1, 2, 3);
    drain();
    check("rearm_pulses", 32'(pulses), 32'd1);

    pulses = 0;
    repeat (4) run3(1, 2, 3);
    drain();
    check("sat_pulses", 32'(pulses), 32'd4);
    check("sat_count", 32'(match_count),
          CNT_ON ? 32'(CMAX) : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised successor to the fixed 2-bit-input, 2-flop Mealy sequence recogniser.
- Detects a runtime-programmable sequence of SEQ_LEN symbols, each SYM_W bits wide, on a registered input stream with a valid qualifier.
- Supports overlapping and non-overlapping match modes and an optional saturating match counter.
- Sits between the input synchroniser/registers and the display/decision logic; emits a one-cycle match pulse.

Parameters:
- SYM_W, 2, symbol width in bits (>=1).
- SEQ_LEN, 4, symbols in the target sequence (>=2).
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  detector armed; low forces IDLE.
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled every cycle.
- cfg_load  input  1  load pattern into the pattern register.
- pattern  input  SEQ_LEN*SYM_W  target sequence; bits [SYM_W-1:0] = oldest (first) symbol.
- x  input  SYM_W  input symbol.
- x_valid  input  1  x is a valid symbol this cycle.
- z  output  1  match pulse, one cycle wide.
- state  output  2  current FSM state, for debug.
- cfg_err  output  1  one-cycle pulse: cfg_load rejected.
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (reset=0, async): all registers cleared; z=0, state=IDLE(2'b00), cfg_err=0, match_count=0, pattern register=0, fill count=0.
- Input stage: x/x_valid registered every clk into x_q/v_q. Window and compare act on x_q/v_q. Latency is 2 cycles: a symbol presented before edge N produces z high in the cycle after edge N+1.
- Window: SEQ_LEN-deep symbol shift register; it shifts only when v_q=1. Cycles with v_q=0 leave window and fill unchanged, so gaps never break a sequence.
- FSM:
  - IDLE(00): enable=0. Fill cleared, z=0. On enable=1, go to FILL.
  - FILL(01): counts accepted symbols. When the accepted symbol makes fill=SEQ_LEN, compare in the same edge and go to RUN.
  - RUN(10): every accepted symbol is compared against the full window-plus-new-symbol.
  - From any state, enable=0 returns to IDLE at the next edge and clears fill.
  - 2'b11 is unused; decode it as IDLE.
- Match: registered z=1 when v_q=1, the state is FILL-completing or RUN, and the shifted window equals the pattern register.
  - overlap=1: stay in or enter RUN; the window is retained.
  - overlap=0: fill cleared and state goes to FILL. The next match needs SEQ_LEN fresh symbols.
- Config: cfg_load accepted only in IDLE, where the pattern register <= pattern. In FILL/RUN it is ignored, cfg_err pulses for 1 cycle, and the pattern is unchanged. When cfg_load and enable rise in the same cycle in IDLE, the load is accepted and the state goes to FILL.
- Reset mid-operation: async clear. The first post-reset match needs SEQ_LEN new symbols.
- match_count: increments on each z pulse and saturates at 2^CNT_W-1 (no wrap). It is held while in IDLE and cleared only by reset.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined: match_count logic is present as specified above.
- Undefined: counter register is removed; match_count is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package seq_det_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_FILL=2'b01, ST_RUN=2'b10;
  - a localparam helper for the fill-counter width, clog2(SEQ_LEN+1).
- One natural sub-module: seq_sym_window, the SEQ_LEN x SYM_W enable-gated shift register with async active-low clear. The top holds the input register, FSM, comparator and counter.

Test Plan:
All scenarios use SYM_W=2, SEQ_LEN=3, pattern {3,2,1} (oldest 1).
- Basic match: load in IDLE, enable=1, stream 1,2,3 with x_valid=1 -> z=1 for exactly one cycle, 2 cycles after the 3 is presented; match_count=1.
- Overlap: pattern {1,1,1}, stream 1,1,1,1,1 -> overlap=1 gives 3 z pulses; overlap=0 gives 1 pulse (second would need 6 symbols).
- Valid gaps: 1,(x_valid=0 for 4 cycles, x=3),2,3 -> single z pulse; the invalid x=3 is ignored. Stream 1,2,2,3 -> no pulse.
- Config guard: cfg_load with pattern {0,0,0} while in RUN -> cfg_err pulse; subsequent 1,2,3 still matches.
- Reset mid-stream: 1,2, assert reset for 1 cycle, then 3 -> no pulse; all outputs 0 during reset. Then 1,2,3 -> pulse.
- Saturation (CNT_W=2, SEQ_DET_COUNT_EN defined): 5 matches -> match_count sticks at 3. Without the macro -> match_count=0 throughout.
